// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator: extends the RISC-V immediate selected by in_sel
// to XLEN bits and buffers results in a 2-entry valid/ready FIFO.
module imm_ext_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_sel,
    output logic             out_err,
    output logic [CNT_W-1:0] ext_count
);

    typedef enum logic [2:0] {
        SEL_I   = 3'b000,
        SEL_S   = 3'b001,
        SEL_B   = 3'b010,
        SEL_J   = 3'b011,
        SEL_U   = 3'b100,
        SEL_Z   = 3'b101,
        SEL_SH  = 3'b110,
        SEL_BAD = 3'b111
    } immSel_t;

    immSel_t            selIn;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    extImm;
    logic               extErr;

    logic [1:0]         count;
    logic [XLEN-1:0]    tailImm;
    logic [2:0]         tailSel;
    logic               tailErr;
    logic               push;
    logic               pop;
    logic               unusedOpcode;

    assign selIn        = immSel_t'(in_sel);
    assign unusedOpcode = ^in_instr[6:0];

    // Signed formats are built at 32 bits and then sign-extended to XLEN in one place.
    always_comb begin
        imm32  = '0;
        extImm = '0;
        extErr = 1'b0;
        case (selIn)
            SEL_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            SEL_J: imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            SEL_U: imm32 = {in_instr[31:12], 12'h000};
            default: ;
        endcase
        extImm = XLEN'(imm32);
        case (selIn)
            SEL_Z:  extImm[4:0] = in_instr[19:15];
            SEL_SH: begin
                extImm[4:0] = in_instr[24:20];
                if (XLEN == 64) extImm[5] = in_instr[25];
            end
            SEL_BAD: extErr = 1'b1;
            default: ;
        endcase
    end

    assign in_ready  = (count != 2'd2) & ~rst;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head lives directly in the output registers, so it keeps the last popped value when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            out_imm   <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            tailImm   <= '0;
            tailSel   <= '0;
            tailErr   <= 1'b0;
            ext_count <= '0;
        end else begin
            if (pop) ext_count <= ext_count + CNT_W'(1);
            if (flush) begin
                count <= '0;
            end else begin
                case (count)
                    2'd0: begin
                        if (push) begin
                            out_imm <= extImm;
                            out_sel <= in_sel;
                            out_err <= extErr;
                            count   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && pop) begin
                            out_imm <= extImm;
                            out_sel <= in_sel;
                            out_err <= extErr;
                        end else if (push) begin
                            tailImm <= extImm;
                            tailSel <= in_sel;
                            tailErr <= extErr;
                            count   <= 2'd2;
                        end else if (pop) begin
                            count <= 2'd0;
                        end
                    end
                    default: begin
                        if (pop) begin
                            out_imm <= tailImm;
                            out_sel <= tailSel;
                            out_err <= tailErr;
                            count   <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: an XLEN=32 instance with the default counter
// and an XLEN=64 instance with a 4-bit counter for wrap-around.
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        aFlush = 1'b0, aValid = 1'b0, aOutReady = 1'b0;
    logic [31:0] aInstr = '0;
    logic [2:0]  aSel = '0;
    logic        aReady, aOutValid, aOutErr;
    logic [2:0]  aOutSel;
    logic [31:0] aOutImm;
    logic [15:0] aExtCount;
    logic [63:0] aExp = '0;
    logic        aExpErr = 1'b0;

    logic        bFlush = 1'b0, bValid = 1'b0, bOutReady = 1'b1;
    logic [31:0] bInstr = '0;
    logic [2:0]  bSel = '0;
    logic        bReady, bOutValid, bOutErr;
    logic [2:0]  bOutSel;
    logic [63:0] bOutImm;
    logic [3:0]  bExtCount;

    imm_ext_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .flush(aFlush), .in_valid(aValid), .in_ready(aReady),
        .in_instr(aInstr), .in_sel(aSel), .out_valid(aOutValid), .out_ready(aOutReady),
        .out_imm(aOutImm), .out_sel(aOutSel), .out_err(aOutErr), .ext_count(aExtCount)
    );

    imm_ext_pipe #(.XLEN(64), .CNT_W(4)) dut64 (
        .clk(clk), .rst(rst), .flush(bFlush), .in_valid(bValid), .in_ready(bReady),
        .in_instr(bInstr), .in_sel(bSel), .out_valid(bOutValid), .out_ready(bOutReady),
        .out_imm(bOutImm), .out_sel(bOutSel), .out_err(bOutErr), .ext_count(bExtCount)
    );

    int compared   = 0;
    int mismatched = 0;
    int popModel   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  sel;
        logic        err;
    } entry_t;
    entry_t sbq[$];

    logic [31:0] tblIns [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h0080006F, 32'h123450B7};
    logic [2:0]  tblSel [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [63:0] tblExp [5] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFFC, 64'h00000008, 64'h12345000};

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference extension built from sign masks and shifted fields.
    function automatic logic [63:0] refImm(input logic [31:0] ins, input logic [2:0] sel, input int xl);
        logic [63:0] ones;
        logic [63:0] v;
        ones = ins[31] ? '1 : '0;
        case (sel)
            3'd0: v = (ones << 12) | 64'(ins[31:20]);
            3'd1: v = (ones << 12) | (64'(ins[31:25]) << 5) | 64'(ins[11:7]);
            3'd2: v = (ones << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            3'd3: v = (ones << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            3'd4: v = (ones << 32) | (64'(ins[31:12]) << 12);
            3'd5: v = 64'(ins[19:15]);
            3'd6: v = (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
            default: v = '0;
        endcase
        if (xl == 32) v[63:32] = '0;
        return v;
    endfunction

    // Handshakes are judged at the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin
        entry_t e;
        if (rst) begin
            sbq.delete();
            popModel = 0;
        end else begin
            if (aOutValid && aOutReady) begin
                popModel++;
                if (sbq.size() == 0) begin
                    checkVal("sbEmptyPop", 64'(aOutValid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    checkVal("sbImm", 64'(aOutImm), e.imm);
                    checkVal("sbSel", 64'(aOutSel), 64'(e.sel));
                    checkVal("sbErr", 64'(aOutErr), 64'(e.err));
                end
            end
            if (aFlush) sbq.delete();
            else if (aValid && aReady) sbq.push_back('{aExp, aSel, aExpErr});
        end
    end

    task automatic sendA(input logic [31:0] ins, input logic [2:0] sel, input logic [63:0] exp);
        aValid  = 1'b1;
        aInstr  = ins;
        aSel    = sel;
        aExp    = exp;
        aExpErr = (sel == 3'd7);
        @(posedge clk); #1;
    endtask

    task automatic sendB(input logic [31:0] ins, input logic [2:0] sel);
        bValid = 1'b1;
        bInstr = ins;
        bSel   = sel;
        @(posedge clk); #1;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) checkVal("drainTimeout", 64'(sbq.size()), 64'd0);
        checkVal("drainedValid", 64'(aOutValid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [2:0]  heldSel;
        logic [15:0] ecSnap;
        logic [31:0] ins;
        logic [2:0]  sel;

        repeat (3) @(posedge clk);
        #1;
        checkVal("rstInReady", 64'(aReady), 64'd0);
        checkVal("rstOutValid", 64'(aOutValid), 64'd0);
        checkVal("rstOutImm", 64'(aOutImm), 64'd0);
        checkVal("rstExtCount", 64'(aExtCount), 64'd0);
        checkVal("rstOutValid64", 64'(bOutValid), 64'd0);
        rst = 1'b0;
        #1;
        checkVal("readyAfterRst", 64'(aReady), 64'd1);

        // Back-to-back formats with downstream always ready.
        aOutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sendA(tblIns[i], tblSel[i], tblExp[i]);
            checkVal("latValid", 64'(aOutValid), 64'd1);
            checkVal("latImm", 64'(aOutImm), tblExp[i]);
        end
        aValid = 1'b0;
        @(posedge clk); #1;
        checkVal("extCount5", 64'(aExtCount), 64'd5);

        sendA(32'h000F8073, 3'd5, 64'h1F);
        sendA(32'h01F0D093, 3'd6, 64'h1F);
        sendA(32'hFFFFFFFF, 3'd7, 64'h0);
        checkVal("illegalErr", 64'(aOutErr), 64'd1);
        checkVal("illegalImm", 64'(aOutImm), 64'd0);
        aValid = 1'b0;
        waitDrain(10);

        // Backpressure: three offered, two accepted.
        aOutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins = $urandom;
            sel = 3'($urandom_range(0, 6));
            sendA(ins, sel, refImm(ins, sel, 32));
        end
        aValid = 1'b0;
        checkVal("bpInReady", 64'(aReady), 64'd0);
        checkVal("bpOutValid", 64'(aOutValid), 64'd1);
        held    = aOutImm;
        heldSel = aOutSel;
        repeat (3) @(posedge clk);
        #1;
        checkVal("bpHoldImm", 64'(aOutImm), 64'(held));
        checkVal("bpHoldSel", 64'(aOutSel), 64'(heldSel));
        aOutReady = 1'b1;
        checkVal("bpReadyBeforePop", 64'(aReady), 64'd0);
        @(posedge clk); #1;
        checkVal("bpReadyAfterPop", 64'(aReady), 64'd1);
        waitDrain(10);

        // Flush with a full buffer and a same-cycle offer.
        aOutReady = 1'b0;
        sendA(32'hFFF00093, 3'd0, 64'hFFFFFFFF);
        sendA(32'h123450B7, 3'd4, 64'h12345000);
        ecSnap = aExtCount;
        aFlush = 1'b1;
        sendA(32'h7FF00093, 3'd0, 64'h7FF);
        aFlush = 1'b0;
        aValid = 1'b0;
        checkVal("flushFullValid", 64'(aOutValid), 64'd0);
        checkVal("flushFullReady", 64'(aReady), 64'd1);
        checkVal("flushExtCount", 64'(aExtCount), 64'(ecSnap));

        // Flush with one entry while in_ready is high: the offer is dropped.
        sendA(32'h0080006F, 3'd3, 64'h8);
        aFlush = 1'b1;
        sendA(32'hFE112E23, 3'd1, 64'hFFFFFFFC);
        aFlush = 1'b0;
        aValid = 1'b0;
        checkVal("flushOneValid", 64'(aOutValid), 64'd0);
        aOutReady = 1'b1;
        sendA(32'hFE000EE3, 3'd2, 64'hFFFFFFFC);
        aValid = 1'b0;
        waitDrain(10);

        // Random traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            ins       = $urandom;
            sel       = 3'($urandom_range(0, 7));
            aOutReady = ($urandom_range(0, 3) != 0);
            aFlush    = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sendA(ins, sel, refImm(ins, sel, 32));
            end else begin
                aValid = 1'b0;
                @(posedge clk); #1;
            end
        end
        aFlush    = 1'b0;
        aValid    = 1'b0;
        aOutReady = 1'b1;
        waitDrain(10);
        checkVal("extCountRand", 64'(aExtCount), 64'(popModel[15:0]));

        // Reset with one entry buffered.
        aOutReady = 1'b0;
        sendA(32'h01F0D093, 3'd6, 64'h1F);
        aValid = 1'b0;
        checkVal("preRstImm", 64'(aOutImm), 64'h1F);
        rst = 1'b1;
        @(posedge clk); #1;
        checkVal("midRstInReady", 64'(aReady), 64'd0);
        checkVal("midRstValid", 64'(aOutValid), 64'd0);
        checkVal("midRstImm", 64'(aOutImm), 64'd0);
        checkVal("midRstSel", 64'(aOutSel), 64'd0);
        checkVal("midRstErr", 64'(aOutErr), 64'd0);
        checkVal("midRstExt", 64'(aExtCount), 64'd0);
        rst = 1'b0;
        #1;
        checkVal("postRstReady", 64'(aReady), 64'd1);

        // XLEN=64 formats and 4-bit counter wrap over 17 pops.
        sendB(32'h800000B7, 3'd4);
        checkVal("x64U", bOutImm, 64'hFFFFFFFF80000000);
        sendB(32'h03F00093, 3'd6);
        checkVal("x64SH", bOutImm, 64'h3F);
        sendB(32'h7FF00093, 3'd0);
        checkVal("x64I", bOutImm, 64'h7FF);
        for (int i = 0; i < 14; i++) begin
            ins = $urandom;
            sel = 3'($urandom_range(0, 7));
            sendB(ins, sel);
            checkVal("x64Rand", bOutImm, refImm(ins, sel, 64));
            checkVal("x64RandErr", 64'(bOutErr), 64'(sel == 3'd7));
        end
        bValid = 1'b0;
        @(posedge clk); #1;
        checkVal("wrap17", 64'(bExtCount), 64'd1);
        checkVal("x64Drained", 64'(bOutValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Registered, parametrised immediate generator for the decode stage. It takes a full 32-bit RISC-V instruction word plus an immediate-type select, and produces an XLEN-wide extended immediate through a 2-entry buffer with valid/ready handshakes on both sides. It adds the CSR-zimm and shift-amount formats, an illegal-select flag, a synchronous flush for branch redirects, and a wrap-around count of delivered immediates.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64.
- CNT_W, 16, width of the delivered-immediate counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous drop of all buffered entries.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- in_sel  in  3  immediate type: I=000, S=001, B=010, J=011, U=100, Z=101, SH=110, 111 illegal.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head.
- out_imm  out  XLEN  extended immediate of the head entry.
- out_sel  out  3  in_sel echoed with the head entry.
- out_err  out  1  head entry had an illegal select.
- ext_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

## Operation
- Extension is combinational on the input. The result is written into the buffer on an accepted input, where accepted means in_valid & in_ready.
- Immediate formats (s = in_instr[31], sign-extended to XLEN):
  - I: s, [31:20].
  - S: s, [31:25], [11:7].
  - B: s, [7], [30:25], [11:8], 0.
  - J: s, [19:12], [20], [30:21], 0.
  - U: {[31:12], 12'b0}; for XLEN=64, bits 63:32 are copies of s.
  - Z: zero-extended [19:15].
  - SH: zero-extended [24:20] for XLEN=32; zero-extended [25:20] for XLEN=64.
  - 111: imm = 0, err = 1. All other selects give err = 0.
- Buffer: 2-entry FIFO of {imm, sel, err} with a 2-bit count (0..2).
  - Push on accepted input. Pop on out_valid & out_ready.
- in_ready = (count != 2) & ~rst.
  - Registered, with no combinational path from out_ready.
- out_valid = (count != 0). out_imm, out_sel and out_err always show the head entry.
  - When out_valid = 0 they show the last popped value, or 0 after reset.
- Push and pop in the same cycle:
  - count = 1: count stays 1, and the new entry becomes head next cycle.
  - count = 2: push cannot occur because in_ready = 0.
- flush: next cycle count = 0 and out_valid = 0.
  - Flush overrides a same-cycle push; the input is dropped even though in_ready was high.
  - A same-cycle pop still increments ext_count.
- ext_count increments by 1 on each pop and wraps from 2^CNT_W−1 to 0. flush does not clear it.
- Reset values: count = 0, out_valid = 0, in_ready = 0 during reset and 1 on the first cycle after, out_imm = 0, out_sel = 0, out_err = 0, ext_count = 0. Reset overrides flush, push and pop.

## Timing
- Latency: input accepted at edge N gives out_valid = 1 after edge N, with the entry visible in cycle N+1.
- Throughput: 1 immediate per cycle while out_ready is held high.
- Backpressure with out_ready low:
  - The buffer accepts 2 entries, then in_ready drops.
  - in_ready rises the cycle after the first pop.
- Reset asserted mid-stream clears buffered entries on the next edge. No output handshake is reported for them.
- Holding out_ready low must keep out_imm, out_sel and out_err stable.

## Test plan
- XLEN=32, back-to-back inputs with out_ready=1:
  - I 0xFFF00093 -> 0xFFFFFFFF.
  - S 0xFE112E23 -> 0xFFFFFFFC.
  - B 0xFE000EE3 -> 0xFFFFFFFC.
  - J 0x0080006F -> 0x00000008.
  - U 0x123450B7 -> 0x12345000.
  - Each result arrives one cycle after acceptance; ext_count = 5.
- Z with in_instr[19:15]=11111 -> 0x0000001F. SH 0x01F0D093 -> 0x1F. sel=111 -> imm 0, out_err = 1.
- XLEN=64:
  - U 0x800000B7 -> 0xFFFFFFFF80000000.
  - SH with [25:20]=111111 -> 0x3F.
  - I 0x7FF00093 -> 0x7FF.
- Backpressure: out_ready=0 and push 3 inputs -> only 2 accepted and in_ready = 0.
  - Raise out_ready -> entries drain in order and in_ready returns to 1 one cycle after the first pop.
- flush with count=2 and in_valid=1 in the same cycle -> next cycle out_valid = 0, count = 0, and the input is dropped; ext_count is unchanged.
- CNT_W=4, 17 pops -> ext_count = 1. Reset mid-stream with count=1 -> all outputs return to their reset values.
